play_timer: RTL and testbench

Playback elapsed-time counter for the music player. Produces the `cnt_sec`/`cnt_min` time-code that the end-of-track detector compares against each track's length. It consumes that detector's registered end flag, `cnt_clc2`, to clear itself. It also runs the play/pause control state and emits a one-cycle pulse per elapsed second for the display and tone-sequencing logic.

---
 rtl/music_pkg.sv | 14 +
 rtl/sec_prescaler.sv | 52 +++++
 rtl/play_timer.sv | 143 ++++++++++++++
 tb/tb_play_timer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared constants for the music player: play-state encoding, time-code width
// and the default system clock rate.
package music_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2
   } play_st_e;

   localparam int TIME_W       = 8;
   localparam int CLK_FREQ_DEF = 50_000_000;

endpackage : music_pkg

// File: rtl/sec_prescaler.sv
// One-second prescaler: counts clk cycles 0..CLK_FREQ-1 while enabled and
// flags the terminal cycle so the caller can count an elapsed second.
module sec_prescaler #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int DIV_W = $clog2(CLK_FREQ);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_FREQ - 1);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;
   logic             term_cnt;

   assign term_cnt = (div_cnt_q == DIV_LAST);

   // tick is combinational so the caller's registered outputs update on the
   // same edge where the prescaler wraps.
   assign tick = en && term_cnt;

   // Next prescaler value: clear wins, then wrap or count while enabled,
   // otherwise hold (this is what freezes the phase during a pause).
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (clr) begin
         div_cnt_d = '0;
      end else if (en) begin
         if (term_cnt) begin
            div_cnt_d = '0;
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
      end else begin
         div_cnt_d = div_cnt_q;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

endmodule : sec_prescaler

// File: rtl/play_timer.sv
// Playback elapsed-time counter: play/pause FSM, mm:ss time-code and a
// one-cycle pulse per elapsed second. Cleared by the end-of-track detector
// (cnt_clc2) and by any change of the selected track.
module play_timer
   import music_pkg::*;
#(
   parameter int CLK_FREQ = CLK_FREQ_DEF,
   parameter int SEC_MAX  = 59,
   parameter int MIN_MAX  = 99
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              play_key,
   input  logic              pause_key,
   input  logic [1:0]        music_reg,
   input  logic              cnt_clc2,
   output logic [TIME_W-1:0] cnt_sec,
   output logic [TIME_W-1:0] cnt_min,
   output logic              sec_tick,
   output logic [1:0]        play_state
);

   localparam logic [TIME_W-1:0] SEC_LAST = TIME_W'(SEC_MAX);
   localparam logic [TIME_W-1:0] MIN_LAST = TIME_W'(MIN_MAX);

   play_st_e          state_q,    state_d;
   logic [1:0]        music_d_q,  music_d_d;
   logic [TIME_W-1:0] cnt_sec_q,  cnt_sec_d;
   logic [TIME_W-1:0] cnt_min_q,  cnt_min_d;
   logic              sec_tick_q, sec_tick_d;

   logic track_chg;
   logic presc_en;
   logic presc_clr;
   logic presc_tick;
   logic at_limit;

   assign track_chg = (music_reg != music_d_q);
   assign at_limit  = (cnt_min_q == MIN_LAST) && (cnt_sec_q == SEC_LAST);

   // The prescaler only advances in PLAY when nothing of higher priority
   // (clear, track change, pause) claims the cycle; a pause on the terminal
   // count therefore leaves it parked at CLK_FREQ-1 with no tick.
   assign presc_en  = (state_q == ST_PLAY) && !pause_key && !cnt_clc2 && !track_chg;
   assign presc_clr = cnt_clc2 || track_chg || (state_q == ST_IDLE);

   sec_prescaler #(
      .CLK_FREQ (CLK_FREQ)
   ) u_sec_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (presc_en),
      .clr   (presc_clr),
      .tick  (presc_tick)
   );

   // Next play state: end-of-track clear, then track change, then keys.
   always_comb begin
      state_d = state_q;
      if (cnt_clc2) begin
         state_d = ST_IDLE;
      end else if (track_chg) begin
         if (music_reg == 2'd0) begin
            state_d = ST_IDLE;
         end else begin
            state_d = state_q;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (play_key && (music_reg != 2'd0)) begin
                  state_d = ST_PLAY;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_PLAY: begin
               if (pause_key) begin
                  state_d = ST_PAUSE;
               end else begin
                  state_d = ST_PLAY;
               end
            end
            ST_PAUSE: begin
               if (play_key) begin
                  state_d = ST_PLAY;
               end else begin
                  state_d = ST_PAUSE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Next time-code and second pulse; the count freezes at MIN_MAX:SEC_MAX.
   always_comb begin
      cnt_sec_d  = cnt_sec_q;
      cnt_min_d  = cnt_min_q;
      sec_tick_d = 1'b0;
      music_d_d  = music_reg;
      if (cnt_clc2 || track_chg) begin
         cnt_sec_d = '0;
         cnt_min_d = '0;
      end else if (presc_tick && !at_limit) begin
         sec_tick_d = 1'b1;
         if (cnt_sec_q == SEC_LAST) begin
            cnt_sec_d = '0;
            cnt_min_d = cnt_min_q + TIME_W'(1);
         end else begin
            cnt_sec_d = cnt_sec_q + TIME_W'(1);
         end
      end else begin
         cnt_sec_d = cnt_sec_q;
         cnt_min_d = cnt_min_q;
      end
   end

   // State, track copy and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         music_d_q  <= 2'd0;
         cnt_sec_q  <= '0;
         cnt_min_q  <= '0;
         sec_tick_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         music_d_q  <= music_d_d;
         cnt_sec_q  <= cnt_sec_d;
         cnt_min_q  <= cnt_min_d;
         sec_tick_q <= sec_tick_d;
      end
   end

   assign cnt_sec    = cnt_sec_q;
   assign cnt_min    = cnt_min_q;
   assign sec_tick   = sec_tick_q;
   assign play_state = state_q;

endmodule : play_timer

// File: tb/tb_play_timer.sv
// Bench for play_timer with CLK_FREQ = 10: directed scenarios plus a random
// phase, every cycle compared against a total-seconds reference model.
module tb_play_timer;

   localparam int F       = 10;
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 99;
   localparam int CAP     = MIN_MAX * (SEC_MAX + 1) + SEC_MAX;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       play_key;
   logic       pause_key;
   logic [1:0] music_reg;
   logic       cnt_clc2;
   logic [7:0] cnt_sec;
   logic [7:0] cnt_min;
   logic       sec_tick;
   logic [1:0] play_state;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: state 0/1/2, phase within the second, total seconds
   int m_state = 0;
   int m_phase = 0;
   int m_secs  = 0;
   int m_tick  = 0;
   int m_music = 0;

   play_timer #(
      .CLK_FREQ (F),
      .SEC_MAX  (SEC_MAX),
      .MIN_MAX  (MIN_MAX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .play_key   (play_key),
      .pause_key  (pause_key),
      .music_reg  (music_reg),
      .cnt_clc2   (cnt_clc2),
      .cnt_sec    (cnt_sec),
      .cnt_min    (cnt_min),
      .sec_tick   (sec_tick),
      .play_state (play_state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_phase = 0;
      m_secs  = 0;
      m_tick  = 0;
      m_music = 0;
   endtask

   // One clock of the reference model, using the inputs sampled at the edge.
   task automatic model_step();
      m_tick = 0;
      if (cnt_clc2) begin
         m_state = 0; m_phase = 0; m_secs = 0;
      end else if (int'(music_reg) != m_music) begin
         m_phase = 0; m_secs = 0;
         if (music_reg == 2'd0) m_state = 0;
      end else if (m_state == 1 && pause_key) begin
         m_state = 2;
      end else if (play_key && (m_state == 2 || (m_state == 0 && music_reg != 2'd0))) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (m_phase == F - 1) begin
            m_phase = 0;
            if (m_secs < CAP) begin
               m_secs++;
               m_tick = 1;
            end
         end else begin
            m_phase++;
         end
      end
      m_music = int'(music_reg);
   endtask

   task automatic compare_all();
      check_eq("cnt_sec",    int'(cnt_sec),    m_secs % (SEC_MAX + 1));
      check_eq("cnt_min",    int'(cnt_min),    m_secs / (SEC_MAX + 1));
      check_eq("sec_tick",   int'(sec_tick),   m_tick);
      check_eq("play_state", int'(play_state), m_state);
   endtask

   // Apply inputs for one cycle, clock, advance the model, then compare.
   task automatic cyc(input logic pk, input logic pz, input logic [1:0] mr, input logic clc);
      play_key  = pk;
      pause_key = pz;
      music_reg = mr;
      cnt_clc2  = clc;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      int k;
      int ticks;
      int n;
      logic [1:0] mr;

      rst_n = 1'b0; play_key = 1'b0; pause_key = 1'b0; music_reg = 2'd0; cnt_clc2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_sec",   int'(cnt_sec),    0);
      check_eq("rst_min",   int'(cnt_min),    0);
      check_eq("rst_tick",  int'(sec_tick),   0);
      check_eq("rst_state", int'(play_state), 0);
      rst_n = 1'b1;
      model_reset();

      // 1: start counting, reset asynchronously mid-count, then restart
      cyc(1'b0, 1'b0, 2'd1, 1'b0);
      cyc(1'b1, 1'b0, 2'd1, 1'b0);
      repeat (25) cyc(1'b0, 1'b0, 2'd1, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_eq("async_rst_sec",   int'(cnt_sec),    0);
      check_eq("async_rst_state", int'(play_state), 0);
      @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 2'd1, 1'b0);
      cyc(1'b1, 1'b0, 2'd1, 1'b0);
      check_eq("s1_state_play", int'(play_state), 1);
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         if (sec_tick) k = i;
      end
      check_eq("s1_first_tick_cycle", k, F);
      check_eq("s1_first_tick_sec",   int'(cnt_sec), 1);

      // 2: minute rollover, then run to saturation
      ticks = 1;
      n = 0;
      while (ticks < 60 && n < 1000) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         if (sec_tick) ticks++;
         n++;
      end
      check_eq("s2_tick60_sec", int'(cnt_sec), 0);
      check_eq("s2_tick60_min", int'(cnt_min), 1);
      n = 0;
      while (m_secs < CAP && n < 70000) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         n++;
      end
      check_eq("s2_reach_limit", m_secs, CAP);
      ticks = 0;
      repeat (F + 2) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         if (sec_tick) ticks++;
      end
      check_eq("s2_sat_no_tick", ticks, 0);
      check_eq("s2_sat_sec", int'(cnt_sec), 59);
      check_eq("s2_sat_min", int'(cnt_min), 99);

      // 3: pause at prescaler phase 4, resume, next tick 6 cycles later
      cyc(1'b0, 1'b0, 2'd1, 1'b1);
      cyc(1'b1, 1'b0, 2'd1, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 2'd1, 1'b0);
      cyc(1'b0, 1'b1, 2'd1, 1'b0);
      check_eq("s3_state_pause", int'(play_state), 2);
      ticks = 0;
      repeat (50) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         if (sec_tick) ticks++;
      end
      check_eq("s3_no_tick_paused", ticks, 0);
      cyc(1'b1, 1'b0, 2'd1, 1'b0);
      k = 0;
      for (int i = 1; i <= 20 && k == 0; i++) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         if (sec_tick) k = i;
      end
      check_eq("s3_resume_tick_cycle", k, 6);

      // 4: end-of-track clear at 1:23, then restart from 0:00
      n = 0;
      while (!(cnt_min == 8'd1 && cnt_sec == 8'd23) && n < 2000) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         n++;
      end
      check_eq("s4_reached_1_23", int'(cnt_min) * 100 + int'(cnt_sec), 123);
      cyc(1'b0, 1'b0, 2'd1, 1'b1);
      check_eq("s4_clr_sec",   int'(cnt_sec),    0);
      check_eq("s4_clr_min",   int'(cnt_min),    0);
      check_eq("s4_clr_state", int'(play_state), 0);
      cyc(1'b1, 1'b0, 2'd1, 1'b0);
      check_eq("s4_restart_state", int'(play_state), 1);
      check_eq("s4_restart_sec",   int'(cnt_sec),    0);

      // 5: track change while playing at 0:07, then deselect
      n = 0;
      while (!(cnt_min == 8'd0 && cnt_sec == 8'd7) && n < 200) begin
         cyc(1'b0, 1'b0, 2'd1, 1'b0);
         n++;
      end
      check_eq("s5_reached_0_07", int'(cnt_sec), 7);
      cyc(1'b0, 1'b0, 2'd2, 1'b0);
      check_eq("s5_chg_sec",   int'(cnt_sec),    0);
      check_eq("s5_chg_state", int'(play_state), 1);
      cyc(1'b0, 1'b0, 2'd0, 1'b0);
      check_eq("s5_zero_state", int'(play_state), 0);

      // 6: clear, pause and terminal count in one cycle
      cyc(1'b0, 1'b0, 2'd1, 1'b0);
      cyc(1'b1, 1'b0, 2'd1, 1'b0);
      repeat (F - 1) cyc(1'b0, 1'b0, 2'd1, 1'b0);
      check_eq("s6_phase_at_terminal", m_phase, F - 1);
      cyc(1'b0, 1'b1, 2'd1, 1'b1);
      check_eq("s6_tick",  int'(sec_tick),   0);
      check_eq("s6_state", int'(play_state), 0);
      check_eq("s6_sec",   int'(cnt_sec),    0);

      // random phase
      mr = 2'd1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) mr = 2'($urandom_range(0, 3));
         cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 24) == 0), mr,
             ($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_play_timer
